bram_fifo_ctrl: RTL

//  Sequencer turning bram_synch_dual_port into a synchronous FIFO: port A is the write port, port B the read port.

---
 rtl/bram_fifo_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: FIFO sequencer over an external dual-port BRAM with a 2-entry output buffer.
// Optional synchronous flush input enabled by defining BRAM_FIFO_FLUSH_EN.
module bram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef BRAM_FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [DATA_WIDTH-1:0] mem_din_a,
  output logic                  mem_we_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  input  logic [DATA_WIDTH-1:0] mem_dout_b,
  output logic                  mem_we_b
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr, w_mem_cnt;
  logic                  r_fp;
  logic [1:0]            r_ob_cnt, w_slot;
  logic [DATA_WIDTH-1:0] r_ob0, r_ob1;
  logic [ADDR_WIDTH+1:0] r_count;
  logic [2:0]            w_ob_need;
  logic                  w_flush, w_we, w_pop, w_fetch;
`ifdef BRAM_FIFO_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif
  assign w_mem_cnt  = r_wr_ptr - r_rd_ptr;
  assign wr_ready   = (w_mem_cnt != DEPTH) && !w_flush;
  assign w_we       = wr_valid && wr_ready;
  assign rd_valid   = r_ob_cnt != 2'd0;
  assign w_pop      = rd_valid && rd_ready;
  // Occupancy the buffer will have once everything in flight lands; a fetch may only add to it below 2
  assign w_ob_need  = {1'b0, r_ob_cnt} + {2'b0, r_fp} - {2'b0, w_pop};
  assign w_fetch    = (w_mem_cnt != '0) && (w_ob_need < 3'd2) && !w_flush;
  assign w_slot     = r_ob_cnt - {1'b0, w_pop};
  assign rd_data    = r_ob0;
  assign count      = r_count;
  assign mem_addr_a = r_wr_ptr[ADDR_WIDTH-1:0];
  assign mem_din_a  = wr_data;
  assign mem_we_a   = w_we;
  assign mem_addr_b = r_rd_ptr[ADDR_WIDTH-1:0];
  assign mem_we_b   = 1'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fp     <= 1'b0;
      r_ob_cnt <= 2'd0;
      r_ob0    <= '0;
      r_ob1    <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= r_rd_ptr;
      r_fp     <= 1'b0;
      r_ob_cnt <= 2'd0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_we};
      r_rd_ptr <= r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_fetch};
      r_fp     <= w_fetch;
      r_ob_cnt <= r_ob_cnt + {1'b0, r_fp} - {1'b0, w_pop};
      r_count  <= r_count + {{(ADDR_WIDTH+1){1'b0}}, w_we} - {{(ADDR_WIDTH+1){1'b0}}, w_pop};
      if (w_pop) r_ob0 <= r_ob1;
      // A landing goes to the first free slot after the pop shift, overriding the shift into slot 0
      if (r_fp && w_slot == 2'd0) r_ob0 <= mem_dout_b;
      if (r_fp && w_slot == 2'd1) r_ob1 <= mem_dout_b;
    end
  end
endmodule
